// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the pipeline registers.
// Holds the state encodings, the flush counter width and the NOP control word.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // FLUSH_DEPTH is limited to 1..7, so three bits hold the remaining flush cycles.
    localparam int FLUSH_CNT_W = 3;

    // Control word with every side-effect bit cleared; loaded by the flushed pipeline registers.
    localparam logic [31:0] NOP_CTRL = 32'h0000_0000;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
// Counts up while enabled and then holds at all-ones.
module pipeline_stall_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Decodes per-stage enables, flushes and bubbles from the RUN/FLUSH/HALT FSM and the hazard inputs.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ral_hazard,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       debug_state
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_DEPTH - 1);

    state_t                 state, state_n;
    logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_n;
    logic                   stall_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
        end
    end

    // Priority within RUN/FLUSH: dmem_busy > halt_req > branch_taken > ral_hazard.
    always_comb begin
        state_n      = state;
        flush_cnt_n  = flush_cnt;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            if (state == ST_HALT) begin
                halted = 1'b1;
                if (resume) begin
                    state_n = ST_RUN;
                end
            end else if (dmem_busy) begin
                // Whole pipeline holds; FSM and flush counter frozen.
            end else if (halt_req) begin
                state_n     = ST_HALT;
                flush_cnt_n = '0;
            end else if (branch_taken) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_write  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_write = 1'b1;
                if (FLUSH_DEPTH > 1) begin
                    state_n     = ST_FLUSH;
                    flush_cnt_n = FLUSH_RELOAD;
                end else begin
                    state_n     = ST_RUN;
                    flush_cnt_n = '0;
                end
            end else if (state == ST_FLUSH) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
                if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                    state_n     = ST_RUN;
                    flush_cnt_n = '0;
                end else begin
                    flush_cnt_n = flush_cnt - FLUSH_CNT_W'(1);
                end
            end else if (ral_hazard) begin
                id_ex_write  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_write = 1'b1;
            end else begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
            end
        end
    end

    assign stall_en    = !rst && !pc_write && (state != ST_HALT);
    assign debug_state = state;

    pipeline_stall_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_en),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl with FLUSH_DEPTH=3 and a 4-bit stall counter.
// Directed scenarios followed by random stimulus, compared against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int D     = 3;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ral_hazard, branch_taken, dmem_busy, halt_req, resume;
    logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, halted;
    logic [CW-1:0] stall_count;
    logic [1:0]    debug_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: halted flag, flush cycles still owed after the current one, stall total.
    bit m_halted;
    int m_flush_left;
    int m_stall;

    pipeline_stall_ctrl #(
        .FLUSH_DEPTH (D),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ral_hazard   (ral_hazard),
        .branch_taken (branch_taken),
        .dmem_busy    (dmem_busy),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_write (ex_mem_write),
        .halted       (halted),
        .stall_count  (stall_count),
        .debug_state  (debug_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, halted}.
    function automatic logic [6:0] model_outputs();
        if (rst)               return 7'b000_000_0;
        if (m_halted)          return 7'b000_000_1;
        if (dmem_busy)         return 7'b000_000_0;
        if (halt_req)          return 7'b000_000_0;
        if (branch_taken)      return 7'b111_111_0;
        if (m_flush_left > 0)  return 7'b111_101_0;
        if (ral_hazard)        return 7'b000_111_0;
        return 7'b110_101_0;
    endfunction

    task automatic model_advance(input logic [6:0] o);
        if (!m_halted && !o[6]) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
        if (m_halted) begin
            if (resume) m_halted = 1'b0;
        end else if (dmem_busy) begin
        end else if (halt_req) begin
            m_halted     = 1'b1;
            m_flush_left = 0;
        end else if (branch_taken) begin
            m_flush_left = D - 1;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
    endtask

    task automatic drive(input bit br, input bit ral, input bit busy, input bit hr, input bit res);
        branch_taken = br;
        ral_hazard   = ral;
        dmem_busy    = busy;
        halt_req     = hr;
        resume       = res;
    endtask

    // One cycle: inputs already applied; check mid-cycle, advance model, cross the edge.
    task automatic step(input string tag);
        logic [6:0] exp_o;
        @(negedge clk);
        exp_o = model_outputs();
        check_val({tag, ":ctrl"}, {25'd0, pc_write, if_id_write, if_id_flush, id_ex_write,
                                   id_ex_bubble, ex_mem_write, halted}, {25'd0, exp_o});
        check_val({tag, ":stall_count"}, {28'd0, stall_count}, 32'(m_stall));
        model_advance(exp_o);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m_halted     = 1'b0;
        m_flush_left = 0;
        m_stall      = 0;
        @(negedge clk);
        check_val("reset:ctrl", {25'd0, pc_write, if_id_write, if_id_flush, id_ex_write,
                                 id_ex_bubble, ex_mem_write, halted}, 32'd0);
        check_val("reset:stall_count", {28'd0, stall_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply_reset();

        step("idle0");
        drive(0, 1, 0, 0, 0); step("ral_pulse");
        drive(0, 0, 0, 0, 0); step("ral_after");

        drive(1, 0, 0, 0, 0); step("br_a0");
        drive(0, 0, 0, 0, 0); step("br_a1");
        step("br_a2");
        step("br_a3_run");

        drive(1, 0, 0, 0, 0); step("br_b0");
        drive(1, 1, 0, 0, 0); step("br_b1_reload");
        drive(0, 1, 0, 0, 0); step("br_b2_ralign");
        drive(0, 0, 0, 0, 0); step("br_b3");
        step("br_b4_run");

        drive(1, 0, 0, 0, 0); step("busy_br");
        drive(0, 0, 0, 0, 0); step("busy_flush1");
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 1, 0); step("busy_hold");
        end
        drive(0, 0, 0, 0, 0); step("busy_last_flush");
        step("busy_run");

        drive(1, 0, 0, 1, 0); step("halt_req_br");
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, i[0], 1, 0); step("halted");
        end
        drive(0, 0, 0, 0, 1); step("resume");
        drive(0, 0, 0, 0, 0); step("post_resume");

        drive(1, 0, 0, 0, 0); step("midflush_br");
        drive(0, 0, 0, 0, 0);
        #2;
        apply_reset();
        step("after_midflush_rst");

        drive(0, 0, 0, 1, 0); step("halt_again");
        drive(0, 0, 0, 0, 0); step("in_halt");
        apply_reset();
        step("after_midhalt_rst");

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            step("random");
        end

        drive(0, 0, 0, 0, 1); step("clear_halt");
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0, 0); step("saturate");
        end
        drive(0, 0, 0, 0, 0); step("sat_hold");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
